// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: observed 7-segment display bus plus the recovered frame.
// master drives the display lines, slave is the decoder.
interface seg_scan_decoder_if;
    logic [7:0] seg;
    logic [3:0] digit;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic       frame_valid;
    logic       bad_glyph;
    logic       stall;
    logic [3:0] dp_out;

    modport master (
        output seg, digit,
        input  units, tens, hundreds, thousands, frame_valid, bad_glyph, stall, dp_out
    );

    modport slave (
        input  seg, digit,
        output units, tens, hundreds, thousands, frame_valid, bad_glyph, stall, dp_out
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers four decimal digits from a multiplexed 7-segment scan.
// Define SEG_SCAN_DP_CAPTURE_EN to also capture the per-digit decimal points.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input logic               clk,
    input logic               rst,
    seg_scan_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_VAL = 24'(TIMEOUT_CYCLES);

    state_t      state, state_nx;
    logic [7:0]  seg_m, seg_s;
    logic [3:0]  dig_m, dig_s;
    logic [7:0]  cmp_seg;
    logic [7:0]  hold_seg, hold_seg_nx;
    logic [3:0]  hold_dig, hold_dig_nx;
    logic [7:0]  settle_cnt, settle_cnt_nx;
    logic        legal, changed, capture;
    logic [1:0]  slot;
    logic [3:0]  glyph_val;
    logic [3:0]  mask, mask_nx;
    logic [3:0]  stage [4];
    logic [23:0] to_cnt, to_cnt_nx;
    logic        timed_out;
    logic [3:0]  units_q, tens_q, hundreds_q, thousands_q;
    logic        frame_valid_q, bad_glyph_q, stall_q;

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 4'd0;
            7'b1111001: decode = 4'd1;
            7'b0100100: decode = 4'd2;
            7'b0110000: decode = 4'd3;
            7'b0011001: decode = 4'd4;
            7'b0010010: decode = 4'd5;
            7'b0000010: decode = 4'd6;
            7'b1111000: decode = 4'd7;
            7'b0000000: decode = 4'd8;
            7'b0010000: decode = 4'd9;
            default:    decode = 4'hF;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m <= '1;
            seg_s <= '1;
            dig_m <= '1;
            dig_s <= '1;
        end else begin
            seg_m <= bus.seg;
            seg_s <= seg_m;
            dig_m <= bus.digit;
            dig_s <= dig_m;
        end
    end

`ifdef SEG_SCAN_DP_CAPTURE_EN
    assign cmp_seg = seg_s;
`else
    logic unused_dp;
    assign unused_dp = seg_s[7];
    assign cmp_seg   = {1'b0, seg_s[6:0]};
`endif

    assign legal   = (dig_s == 4'b1110) || (dig_s == 4'b1101) ||
                     (dig_s == 4'b1011) || (dig_s == 4'b0111);
    assign changed = (dig_s != hold_dig) || (cmp_seg != hold_seg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            hold_seg   <= '1;
            hold_dig   <= '1;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            hold_seg   <= hold_seg_nx;
            hold_dig   <= hold_dig_nx;
            settle_cnt <= settle_cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        hold_seg_nx   = hold_seg;
        hold_dig_nx   = hold_dig;
        settle_cnt_nx = settle_cnt;
        capture       = 1'b0;
        case (state)
            S_IDLE: begin
                if (legal) begin
                    hold_seg_nx   = cmp_seg;
                    hold_dig_nx   = dig_s;
                    settle_cnt_nx = '0;
                    state_nx      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!legal) begin
                    state_nx = S_IDLE;
                end else if (changed) begin
                    hold_seg_nx   = cmp_seg;
                    hold_dig_nx   = dig_s;
                    settle_cnt_nx = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nx = S_CAPTURE;
                end else begin
                    settle_cnt_nx = settle_cnt + 8'd1;
                end
            end
            S_CAPTURE: begin
                capture  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // a change re-enters the IDLE decision on this same cycle
                if (changed) begin
                    if (legal) begin
                        hold_seg_nx   = cmp_seg;
                        hold_dig_nx   = dig_s;
                        settle_cnt_nx = '0;
                        state_nx      = S_SETTLE;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        case (hold_dig)
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: slot = 2'd0;
        endcase
    end

    assign glyph_val = decode(hold_seg[6:0]);
    assign to_cnt_nx = capture ? '0 : ((to_cnt == '1) ? to_cnt : to_cnt + 24'd1);
    assign timed_out = !capture && (to_cnt_nx >= TIMEOUT_VAL);

    always_comb begin
        mask_nx = mask;
        if (mask == 4'b1111 || timed_out) begin
            mask_nx = '0;
        end
        if (capture) begin
            mask_nx = mask_nx | ~hold_dig;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                stage[i] <= 4'hF;
            end
            mask          <= '0;
            to_cnt        <= '0;
            units_q       <= 4'hF;
            tens_q        <= 4'hF;
            hundreds_q    <= 4'hF;
            thousands_q   <= 4'hF;
            frame_valid_q <= 1'b0;
            bad_glyph_q   <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            if (mask == 4'b1111) begin
                units_q       <= stage[0];
                tens_q        <= stage[1];
                hundreds_q    <= stage[2];
                thousands_q   <= stage[3];
                frame_valid_q <= 1'b1;
            end
            if (capture) begin
                stage[slot] <= glyph_val;
                if (glyph_val == 4'hF) begin
                    bad_glyph_q <= 1'b1;
                end
            end
            mask   <= mask_nx;
            to_cnt <= to_cnt_nx;
            if (capture) begin
                stall_q <= 1'b0;
            end else if (timed_out) begin
                stall_q <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_DP_CAPTURE_EN
    logic [3:0] stage_dp, dp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_dp <= '0;
            dp_q     <= '0;
        end else begin
            if (mask == 4'b1111) begin
                dp_q <= stage_dp;
            end
            if (capture) begin
                stage_dp[slot] <= ~hold_seg[7];
            end
        end
    end

    assign bus.dp_out = dp_q;
`else
    assign bus.dp_out = '0;
`endif

    assign bus.units       = units_q;
    assign bus.tens        = tens_q;
    assign bus.hundreds    = hundreds_q;
    assign bus.thousands   = thousands_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.bad_glyph   = bad_glyph_q;
    assign bus.stall       = stall_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and randomized display scans checked against a
// frame-level model of which phases get captured and what each frame must hold.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned TMO    = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [3:0] u;
        logic [3:0] t;
        logic [3:0] h;
        logic [3:0] k;
        logic [3:0] dp;
        logic       bad;
    } frame_t;

    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] m_stage [4];
    logic [3:0] m_dp;
    logic [3:0] m_mask;
    logic       m_bad;
    frame_t     exp_q[$];
    frame_t     last;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] model_decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) begin
            if (glyph_tab[i] == s) return 4'(i);
        end
        return 4'hF;
    endfunction

    function automatic bit is_legal(input logic [3:0] d);
        return $countones(~d) == 1;
    endfunction

    function automatic int slot_of(input logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            if (!d[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [7:0] glyph(input int d, input bit dp_lit);
        return {~dp_lit, glyph_tab[d]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_stage[i] = 4'hF;
        m_dp   = '0;
        m_mask = '0;
        m_bad  = 1'b0;
        exp_q.delete();
        last = '{u: 4'hF, t: 4'hF, h: 4'hF, k: 4'hF, dp: 4'h0, bad: 1'b0};
    endtask

    task automatic model_capture(input int s, input logic [7:0] sg);
        frame_t f;
        m_stage[s] = model_decode(sg[6:0]);
`ifdef SEG_SCAN_DP_CAPTURE_EN
        m_dp[s] = ~sg[7];
`else
        m_dp[s] = 1'b0;
`endif
        if (m_stage[s] == 4'hF) m_bad = 1'b1;
        m_mask[s] = 1'b1;
        if (m_mask == 4'b1111) begin
            f = '{u: m_stage[0], t: m_stage[1], h: m_stage[2], k: m_stage[3], dp: m_dp, bad: m_bad};
            exp_q.push_back(f);
            m_mask = '0;
        end
    endtask

    // A legal phase of 40+ cycles is always captured; one of 8 or fewer never is.
    task automatic phase(input logic [3:0] dig, input logic [7:0] sg, input int unsigned len);
        if (is_legal(dig) && len >= 40) model_capture(slot_of(dig), sg);
        @(posedge clk); #1 bus.digit = dig;
        @(posedge clk); #1 bus.seg = sg;
        repeat (len - 2) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int unsigned len);
        phase(4'b1111, 8'hFF, len);
    endtask

    task automatic scan4(input int th, input int hu, input int te, input int un, input logic [3:0] dps);
        phase(4'b1110, glyph(un, dps[0]), 60); gap(2);
        phase(4'b1101, glyph(te, dps[1]), 60); gap(2);
        phase(4'b1011, glyph(hu, dps[2]), 60); gap(2);
        phase(4'b0111, glyph(th, dps[3]), 60); gap(2);
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (!rst) begin
            if (bus.frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    f = exp_q.pop_front();
                    last = f;
                    check("frame_bad_glyph", int'(bus.bad_glyph), int'(f.bad));
                end
            end
            check("units", int'(bus.units), int'(last.u));
            check("tens", int'(bus.tens), int'(last.t));
            check("hundreds", int'(bus.hundreds), int'(last.h));
            check("thousands", int'(bus.thousands), int'(last.k));
            check("dp_out", int'(bus.dp_out), int'(last.dp));
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  w;
        logic [7:0]  sg;
        int unsigned r;
        bus.seg   = 8'hFF;
        bus.digit = 4'hF;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_units", int'(bus.units), 'hF);
        check("rst_thousands", int'(bus.thousands), 'hF);
        check("rst_frame_valid", int'(bus.frame_valid), 0);
        check("rst_bad_glyph", int'(bus.bad_glyph), 0);
        check("rst_stall", int'(bus.stall), 0);
        check("rst_dp_out", int'(bus.dp_out), 0);
        rst = 1'b0;

        scan4(1, 2, 3, 4, 4'b0000);
        scan4(1, 2, 3, 4, 4'b0000);
        check("lit_1234_units", int'(bus.units), 4);
        check("lit_1234_tens", int'(bus.tens), 3);
        check("lit_1234_hundreds", int'(bus.hundreds), 2);
        check("lit_1234_thousands", int'(bus.thousands), 1);
        check("lit_1234_bad", int'(bus.bad_glyph), 0);

        phase(4'b1110, glyph(4, 0), 60); gap(2);
        phase(4'b1101, 8'hFF, 60); gap(2);
        phase(4'b1011, glyph(2, 0), 60); gap(2);
        phase(4'b0111, glyph(1, 0), 60); gap(2);
        check("lit_blank_tens", int'(bus.tens), 'hF);
        check("lit_blank_bad", int'(bus.bad_glyph), 1);
        scan4(1, 2, 3, 4, 4'b0000);
        check("lit_clean_tens", int'(bus.tens), 3);
        check("lit_bad_sticky", int'(bus.bad_glyph), 1);

        phase(4'b1100, glyph(8, 0), 100); gap(5);
        phase(4'b1110, glyph(7, 0), 60); gap(5);
        phase(4'b1100, glyph(8, 0), 100); gap(5);
        phase(4'b1101, glyph(6, 0), 60); gap(5);
        phase(4'b1011, glyph(5, 0), 60); gap(5);
        phase(4'b0000, glyph(8, 0), 30); gap(5);
        phase(4'b0111, glyph(9, 0), 60); gap(5);
        check("lit_illegal_frame", int'({bus.thousands, bus.hundreds, bus.tens, bus.units}), 'h9567);

        phase(4'b1110, glyph(0, 0), 60);
        phase(4'b1101, glyph(8, 0), 60);
        gap(400);
        check("stall_early", int'(bus.stall), 0);
        gap(250);
        check("stall_set", int'(bus.stall), 1);
        m_mask = '0;
        phase(4'b1011, glyph(3, 0), 60);
        check("stall_cleared", int'(bus.stall), 0);
        gap(2);
        phase(4'b0111, glyph(4, 0), 60); gap(2);
        phase(4'b1110, glyph(5, 0), 60); gap(2);
        phase(4'b1101, glyph(6, 0), 60); gap(2);
        check("lit_after_stall", int'({bus.thousands, bus.hundreds, bus.tens, bus.units}), 'h4365);

        phase(4'b1110, glyph(1, 0), 60); gap(2);
        phase(4'b1101, glyph(1, 0), 60); gap(2);
        phase(4'b1011, glyph(1, 0), 60);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("midrst_units", int'(bus.units), 'hF);
        check("midrst_frame_valid", int'(bus.frame_valid), 0);
        check("midrst_bad", int'(bus.bad_glyph), 0);
        check("midrst_stall", int'(bus.stall), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        gap(3);
        scan4(1, 2, 3, 4, 4'b0100);
        check("lit_after_rst", int'({bus.thousands, bus.hundreds, bus.tens, bus.units}), 'h1234);
`ifdef SEG_SCAN_DP_CAPTURE_EN
        check("lit_dp_12.34", int'(bus.dp_out), 'b0100);
`else
        check("lit_dp_off", int'(bus.dp_out), 0);
`endif

        for (int p = 0; p < 60; p++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                do w = 4'($urandom_range(0, 15)); while (is_legal(w));
                phase(w, 8'($urandom), $urandom_range(10, 100));
                gap($urandom_range(2, 6));
            end else if (r < 4) begin
                w = ~(4'b0001 << $urandom_range(0, 3));
                phase(w, 8'($urandom), $urandom_range(2, 8));
                gap($urandom_range(2, 6));
            end
            w = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) sg = 8'($urandom);
            else sg = glyph($urandom_range(0, 9), bit'($urandom_range(0, 1)));
            phase(w, sg, $urandom_range(40, 90));
            gap($urandom_range(2, 6));
        end

        repeat (50) @(posedge clk);
        #1;
        check("frames_pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
